// File: rtl/audio_spi_pkg.sv
// Shared constants and types for the audio codec SPI register responder.
package audio_spi_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 16;
  localparam int REG_NUM    = 128;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);

  // Index of each SPI pin in the synchroniser bank
  localparam int NUM_PINS = 3;
  localparam int PIN_CS   = 0;
  localparam int PIN_SCLK = 1;
  localparam int PIN_DIN  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  // Bit-count literal of the counter's width, for readable comparisons
  function automatic logic [BIT_CNT_W-1:0] bit_cnt_of(input int n);
    return BIT_CNT_W'(n);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, followed by an edge
// register that produces the delayed level plus one-cycle rise/fall pulses.
// The level output and the pulses change on the same clock edge, so a
// consumer sees a fall pulse exactly when the level first reads low.
module spi_pin_sync (
  input  logic clk,
  input  logic srst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Synchroniser chain; left unreset so it follows the pin through reset and
  // a pin already low at reset release produces no spurious edge.
  always_ff @(posedge clk) begin
    meta_reg <= pin;
    sync_reg <= meta_reg;
    prev_reg <= sync_reg;
  end

  // Edge pulses, registered alongside the delayed level
  always_ff @(posedge clk) begin
    if (srst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= sync_reg & ~prev_reg;
      fall <= ~sync_reg & prev_reg;
    end
  end

  assign level = prev_reg;

endmodule

// File: rtl/audio_spi_reg_slave.sv
// SPI responder for the codec's 16-bit register port: {addr[6:0], rw, data[7:0]},
// MSB first, sampled on SCLK falls. Writes land in a 128 x 8 register file that
// is also visible to the host through iRD_ADDR/oRD_DATA.
// Optional feature macro: AUDIO_SPI_SLAVE_READBACK_EN (read frames shift the
// addressed register out on oDOUT; when undefined oDOUT is held at 0).
module audio_spi_reg_slave
  import audio_spi_pkg::*;
#(
  parameter logic [DATA_W-1:0] RST_VAL  = 8'h00,
  parameter int                MIN_HALF = 4
) (
  input  logic              iCLK_50,
  input  logic              iRESET,
  input  logic              iCS_n,
  input  logic              iSCLK,
  input  logic              iDIN,
  output logic              oDOUT,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oWR_STB,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [DATA_W-1:0] oWR_DATA,
  output logic              oFRAME_ERR,
  output logic [7:0]        oWR_CNT
);

  // The edge pipeline needs at least two cycles per SCLK half to keep edges
  // apart; MIN_HALF is the guaranteed margin above that.
  localparam bit min_half_ok_unused = (MIN_HALF >= 2);

  // ---------------------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------------------
  logic [NUM_PINS-1:0] pin_raw;
  logic [NUM_PINS-1:0] pin_level;
  logic [NUM_PINS-1:0] pin_rise;
  logic [NUM_PINS-1:0] pin_fall;

  assign pin_raw[PIN_CS]   = iCS_n;
  assign pin_raw[PIN_SCLK] = iSCLK;
  assign pin_raw[PIN_DIN]  = iDIN;

  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
    spi_pin_sync pin_sync_inst (
      .clk   (iCLK_50),
      .srst  (iRESET),
      .pin   (pin_raw[gi]),
      .level (pin_level[gi]),
      .rise  (pin_rise[gi]),
      .fall  (pin_fall[gi])
    );
  end

  logic cs_level;
  logic cs_rise;
  logic cs_fall;
  logic sclk_rise;
  logic sclk_fall;
  logic din_level;

  assign cs_level  = pin_level[PIN_CS];
  assign cs_rise   = pin_rise[PIN_CS];
  assign cs_fall   = pin_fall[PIN_CS];
  assign sclk_rise = pin_rise[PIN_SCLK];
  assign sclk_fall = pin_fall[PIN_SCLK];
  assign din_level = pin_level[PIN_DIN];

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t                  state;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [FRAME_BITS-2:0]   shift_reg;
  logic                    wr_stb_reg;
  logic                    frame_err_reg;
  logic [ADDR_W-1:0]       wr_addr_reg;
  logic [DATA_W-1:0]       wr_data_reg;
  logic [7:0]              wr_cnt_reg;
  logic [DATA_W-1:0]       reg_file [REG_NUM];

  logic [FRAME_BITS-1:0]   next_frame;
  logic                    frame_done;
  logic                    commit;
  logic [ADDR_W-1:0]       commit_addr;
  logic [DATA_W-1:0]       commit_data;

  // Frame as it will look once the bit arriving this cycle is shifted in
  always_comb begin
    next_frame  = {shift_reg, din_level};
    frame_done  = (state == SHIFT) && sclk_fall &&
                  (bit_cnt == bit_cnt_of(FRAME_BITS - 1));
    commit      = frame_done && !next_frame[DATA_W];
    commit_addr = next_frame[FRAME_BITS-1 -: ADDR_W];
    commit_data = next_frame[DATA_W-1:0];
  end

  // Frame FSM: bit collection, write commit, abort detection, write counters
  always_ff @(posedge iCLK_50) begin
    if (iRESET) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      wr_stb_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_cnt_reg    <= '0;
    end else begin
      wr_stb_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (cs_fall) begin
            state <= SHIFT;
          end else if (!cs_level) begin
            // CS was already low without a visible edge (e.g. held through
            // reset): sit out the rest of that frame.
            state <= WAIT_CS;
          end
        end
        SHIFT: begin
          if (sclk_fall) begin
            shift_reg <= next_frame[FRAME_BITS-2:0];
            bit_cnt   <= bit_cnt + bit_cnt_of(1);
          end
          if (frame_done) begin
            if (commit) begin
              wr_stb_reg  <= 1'b1;
              wr_addr_reg <= commit_addr;
              wr_data_reg <= commit_data;
              wr_cnt_reg  <= wr_cnt_reg + 8'd1;
            end
            // A CS rise coinciding with the last fall has already happened,
            // so there is nothing left to wait for.
            state <= cs_rise ? IDLE : WAIT_CS;
          end else if (cs_rise) begin
            frame_err_reg <= 1'b1;
            state         <= IDLE;
          end
        end
        WAIT_CS: begin
          if (cs_level) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register file: reset to RST_VAL, written once per committed frame
  always_ff @(posedge iCLK_50) begin
    if (iRESET) begin
      for (int i = 0; i < REG_NUM; i++) begin
        reg_file[i] <= RST_VAL;
      end
    end else if (commit) begin
      reg_file[commit_addr] <= commit_data;
    end
  end

  assign oRD_DATA   = reg_file[iRD_ADDR];
  assign oWR_STB    = wr_stb_reg;
  assign oWR_ADDR   = wr_addr_reg;
  assign oWR_DATA   = wr_data_reg;
  assign oFRAME_ERR = frame_err_reg;
  assign oWR_CNT    = wr_cnt_reg;

  // ---------------------------------------------------------------------------
  // Read-back path
  // ---------------------------------------------------------------------------
`ifdef AUDIO_SPI_SLAVE_READBACK_EN
  logic [DATA_W-1:0] tx_reg;
  logic              rw_reg;
  logic              dout_reg;

  // Load tx on the 8th fall of a read, then present one bit per SCLK rise
  // on the rises that precede sampled bits 9..16
  always_ff @(posedge iCLK_50) begin
    if (iRESET) begin
      tx_reg   <= '0;
      rw_reg   <= 1'b0;
      dout_reg <= 1'b0;
    end else if (state == SHIFT) begin
      if (sclk_fall && (bit_cnt == bit_cnt_of(ADDR_W))) begin
        rw_reg <= next_frame[0];
        tx_reg <= reg_file[next_frame[ADDR_W:1]];
      end else if (sclk_rise && rw_reg && (bit_cnt >= bit_cnt_of(ADDR_W + 1))) begin
        dout_reg <= tx_reg[DATA_W-1];
        tx_reg   <= {tx_reg[DATA_W-2:0], 1'b0};
      end
    end else if ((state == IDLE) || cs_level) begin
      rw_reg   <= 1'b0;
      dout_reg <= 1'b0;
    end
  end

  assign oDOUT = dout_reg;

  logic pins_unused;
  assign pins_unused = pin_level[PIN_SCLK] | pin_rise[PIN_DIN] | pin_fall[PIN_DIN];
`else
  assign oDOUT = 1'b0;

  logic pins_unused;
  assign pins_unused = pin_level[PIN_SCLK] | pin_rise[PIN_DIN] | pin_fall[PIN_DIN] |
                       sclk_rise;
`endif

endmodule

// File: tb/tb_audio_spi_reg_slave.sv
// Self-checking bench for audio_spi_reg_slave: a bit-banged SPI master drives
// frames, a model predicts committed writes into a scoreboard queue, and a
// monitor pops and compares on every oWR_STB.
module tb_audio_spi_reg_slave;

  localparam logic [7:0] RST_VAL = 8'h00;
  localparam int SLOW = 27;
  localparam int FAST = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b1;
  logic       din = 1'b0;
  logic       dout;
  logic [6:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       wr_stb;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [7:0] wr_cnt;

  always #10 clk = ~clk;

  audio_spi_reg_slave #(.RST_VAL(RST_VAL), .MIN_HALF(4)) dut (
    .iCLK_50    (clk),
    .iRESET     (rst),
    .iCS_n      (cs_n),
    .iSCLK      (sclk),
    .iDIN       (din),
    .oDOUT      (dout),
    .iRD_ADDR   (rd_addr),
    .oRD_DATA   (rd_data),
    .oWR_STB    (wr_stb),
    .oWR_ADDR   (wr_addr),
    .oWR_DATA   (wr_data),
    .oFRAME_ERR (frame_err),
    .oWR_CNT    (wr_cnt)
  );

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] cnt;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_exp;
  wr_t        mon_got;
  int         checks = 0;
  int         fails = 0;
  int         err_pulses = 0;
  logic [7:0] model_regs [128];
  logic [7:0] model_cnt;

`ifdef AUDIO_SPI_SLAVE_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  // Scoreboard monitor: every strobe must match the oldest predicted write
  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (wr_stb) begin
      checks++;
      mon_got.addr = wr_addr;
      mon_got.data = wr_data;
      mon_got.cnt  = wr_cnt;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wr_stb_unexpected: got addr=%h data=%h cnt=%0d, required no strobe",
                 wr_addr, wr_data, wr_cnt);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          fails++;
          $display("FAIL wr_commit: got addr=%h data=%h cnt=%0d, required addr=%h data=%h cnt=%0d",
                   wr_addr, wr_data, wr_cnt, mon_exp.addr, mon_exp.data, mon_exp.cnt);
        end else begin
          $display("commit addr=%h data=%h cnt=%0d", wr_addr, wr_data, wr_cnt);
        end
      end
    end
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) model_regs[i] = RST_VAL;
    model_cnt = 8'd0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    model_reset();
    tick(4);
  endtask

  task automatic push_write(input logic [6:0] addr, input logic [7:0] data);
    model_regs[addr] = data;
    model_cnt = model_cnt + 8'd1;
    exp_q.push_back('{addr: addr, data: data, cnt: model_cnt});
  endtask

  // Clock out bits [first, first+count) of a frame; master samples MISO on
  // falls of bits 9..16. Optionally raises CS together with the last fall.
  task automatic spi_bits(input logic [15:0] frame, input int first, input int count,
                          input int half, input bit cs_on_last, output logic [7:0] miso);
    logic [15:0] f;
    f = frame;
    miso = 8'h00;
    for (int i = first; i < first + count; i++) begin
      din = f[15-i];
      tick(half);
      if (i >= 8) miso = {miso[6:0], dout};
      sclk = 1'b0;
      if (cs_on_last && (i == first + count - 1)) cs_n = 1'b1;
      tick(half);
      sclk = 1'b1;
    end
  endtask

  task automatic spi_frame(input logic [15:0] frame, input int half, output logic [7:0] miso);
    cs_n = 1'b0;
    tick(half);
    spi_bits(frame, 0, 16, half, 1'b0, miso);
    tick(half);
    cs_n = 1'b1;
    tick(half);
  endtask

  task automatic test_reset();
    logic [6:0] addrs [3];
    addrs[0] = 7'h00; addrs[1] = 7'h22; addrs[2] = 7'h7F;
    checks++; if (dout !== 1'b0) begin fails++; $display("FAIL reset_dout: got %b, required 0", dout); end
    checks++; if (wr_stb !== 1'b0) begin fails++; $display("FAIL reset_wr_stb: got %b, required 0", wr_stb); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    checks++; if (wr_addr !== 7'h00) begin fails++; $display("FAIL reset_wr_addr: got %h, required 00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h, required 00", wr_data); end
    checks++; if (wr_cnt !== 8'h00) begin fails++; $display("FAIL reset_wr_cnt: got %0d, required 0", wr_cnt); end
    for (int i = 0; i < 3; i++) begin
      rd_addr = addrs[i];
      tick(1);
      checks++;
      if (rd_data !== RST_VAL) begin
        fails++;
        $display("FAIL reset_reg[%h]: got %h, required %h", addrs[i], rd_data, RST_VAL);
      end
    end
    $display("reset state checked");
  endtask

  task automatic test_write();
    logic [7:0] miso;
    push_write(7'h22, 8'h01);
    spi_frame({7'h22, 1'b0, 8'h01}, SLOW, miso);
    checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL write_missing: %0d pending, required 0", exp_q.size()); end
    rd_addr = 7'h22;
    tick(1);
    checks++; if (rd_data !== 8'h01) begin fails++; $display("FAIL write_rd_data: got %h, required 01", rd_data); end
    $display("write frame addr=22 data=01 sent");
  endtask

  task automatic test_read();
    logic [7:0] miso;
    logic [7:0] want;
    int         errs0;
    errs0 = err_pulses;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        push_write(7'h22, 8'h9E);
        spi_frame({7'h22, 1'b0, 8'h9E}, SLOW, miso);
      end
      spi_frame({7'h22, 1'b1, 8'hFF}, SLOW, miso);
      want = READBACK ? model_regs[7'h22] : 8'h00;
      checks++;
      if (miso !== want) begin fails++; $display("FAIL read_miso: got %h, required %h", miso, want); end
      rd_addr = 7'h22;
      tick(1);
      checks++;
      if (rd_data !== model_regs[7'h22]) begin
        fails++; $display("FAIL read_reg_unchanged: got %h, required %h", rd_data, model_regs[7'h22]);
      end
      $display("read frame addr=22 returned %h", miso);
    end
    checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL read_pending: %0d pending, required 0", exp_q.size()); end
    checks++; if (err_pulses !== errs0) begin fails++; $display("FAIL read_err: got %0d pulses, required 0", err_pulses - errs0); end
  endtask

  task automatic test_abort();
    logic [7:0] miso;
    int         errs0;
    errs0 = err_pulses;
    cs_n = 1'b0;
    tick(SLOW);
    spi_bits({7'h30, 1'b0, 8'h5A}, 0, 9, SLOW, 1'b0, miso);
    tick(SLOW);
    cs_n = 1'b1;
    tick(SLOW);
    checks++; if (err_pulses - errs0 !== 1) begin fails++; $display("FAIL abort_err: got %0d pulses, required 1", err_pulses - errs0); end
    rd_addr = 7'h30;
    tick(1);
    checks++; if (rd_data !== model_regs[7'h30]) begin fails++; $display("FAIL abort_reg: got %h, required %h", rd_data, model_regs[7'h30]); end
    $display("aborted frame after 9 bits");
    push_write(7'h30, 8'h5A);
    spi_frame({7'h30, 1'b0, 8'h5A}, SLOW, miso);
    checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL abort_next_missing: %0d pending, required 0", exp_q.size()); end
    rd_addr = 7'h30;
    tick(1);
    checks++; if (rd_data !== 8'h5A) begin fails++; $display("FAIL abort_next_reg: got %h, required 5A", rd_data); end
    $display("write frame addr=30 data=5A sent");
  endtask

  task automatic test_cs_on_last_fall();
    logic [7:0] miso;
    int         errs0;
    errs0 = err_pulses;
    push_write(7'h41, 8'h3C);
    cs_n = 1'b0;
    tick(SLOW);
    spi_bits({7'h41, 1'b0, 8'h3C}, 0, 16, SLOW, 1'b1, miso);
    tick(SLOW);
    checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL cs_last_missing: %0d pending, required 0", exp_q.size()); end
    checks++; if (err_pulses !== errs0) begin fails++; $display("FAIL cs_last_err: got %0d pulses, required 0", err_pulses - errs0); end
    push_write(7'h42, 8'hC3);
    spi_frame({7'h42, 1'b0, 8'hC3}, SLOW, miso);
    checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL cs_last_follow: %0d pending, required 0", exp_q.size()); end
    $display("write frames addr=41/42 sent with CS rising on last fall");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] miso;
    int         errs0;
    cs_n = 1'b0;
    tick(SLOW);
    spi_bits({7'h05, 1'b0, 8'hAA}, 0, 12, SLOW, 1'b0, miso);
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    model_reset();
    tick(4);
    errs0 = err_pulses;
    rd_addr = 7'h05;
    tick(1);
    checks++; if (rd_data !== RST_VAL) begin fails++; $display("FAIL midrst_reg: got %h, required %h", rd_data, RST_VAL); end
    checks++; if (dout !== 1'b0) begin fails++; $display("FAIL midrst_dout: got %b, required 0", dout); end
    checks++; if (wr_cnt !== 8'h00) begin fails++; $display("FAIL midrst_cnt: got %0d, required 0", wr_cnt); end
    // CS still low: a whole frame of clocks must be ignored
    spi_bits({7'h05, 1'b0, 8'h77}, 0, 16, SLOW, 1'b0, miso);
    tick(SLOW);
    rd_addr = 7'h05;
    tick(1);
    checks++; if (rd_data !== RST_VAL) begin fails++; $display("FAIL midrst_ignored: got %h, required %h", rd_data, RST_VAL); end
    checks++; if (err_pulses !== errs0) begin fails++; $display("FAIL midrst_err: got %0d pulses, required 0", err_pulses - errs0); end
    cs_n = 1'b1;
    tick(SLOW);
    push_write(7'h06, 8'h12);
    spi_frame({7'h06, 1'b0, 8'h12}, SLOW, miso);
    checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL midrst_next: %0d pending, required 0", exp_q.size()); end
    $display("reset mid-frame, held CS ignored, next write sent");
  endtask

  task automatic test_back_to_back_wrap();
    logic [7:0] miso;
    logic [7:0] want;
    logic [7:0] data;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      data = 8'(i) ^ 8'h5C;
      push_write(7'(i), data);
      spi_frame({7'(i), 1'b0, data}, FAST, miso);
    end
    checks++; if (exp_q.size() !== 0) begin fails++; $display("FAIL wrap_pending: %0d pending, required 0", exp_q.size()); end
    checks++; if (wr_cnt !== 8'h00) begin fails++; $display("FAIL wrap_cnt: got %0d, required 0", wr_cnt); end
    rd_addr = 7'h7F;
    tick(1);
    checks++; if (rd_data !== model_regs[7'h7F]) begin fails++; $display("FAIL wrap_reg127: got %h, required %h", rd_data, model_regs[7'h7F]); end
    spi_frame({7'h7F, 1'b1, 8'hFF}, SLOW, miso);
    want = READBACK ? model_regs[7'h7F] : 8'h00;
    checks++; if (miso !== want) begin fails++; $display("FAIL wrap_read127: got %h, required %h", miso, want); end
    $display("256 back-to-back writes, read addr=7F returned %h", miso);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(4);
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_cs_on_last_fall();
    test_reset_midframe();
    test_back_to_back_wrap();
    tick(10);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
